// File: rtl/rvfi_pc_order_check_if.sv
// RVFI retirement bundle seen by the PC/order checker.
// The harness drives it as master; the checker samples it as slave.
interface rvfi_pc_order_check_if #(
    parameter int NRET    = 1,
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
);
    logic [NRET-1:0]         rvfi_valid;
    logic [NRET*ORDER_W-1:0] rvfi_order;
    logic [NRET*XLEN-1:0]    rvfi_pc_rdata;
    logic [NRET*XLEN-1:0]    rvfi_pc_wdata;
    logic [NRET-1:0]         rvfi_trap;
    logic [NRET-1:0]         rvfi_intr;

    modport master (
        output rvfi_valid,
        output rvfi_order,
        output rvfi_pc_rdata,
        output rvfi_pc_wdata,
        output rvfi_trap,
        output rvfi_intr
    );

    modport slave (
        input rvfi_valid,
        input rvfi_order,
        input rvfi_pc_rdata,
        input rvfi_pc_wdata,
        input rvfi_trap,
        input rvfi_intr
    );
endinterface

// File: rtl/rvfi_pc_order_check.sv
// Multi-channel RVFI retirement checker: shadow PC/order tracking,
// packing, alignment and liveness checks with sticky registered flags.
module rvfi_pc_order_check #(
    parameter int NRET       = 1,
    parameter int XLEN       = 32,
    parameter int ORDER_W    = 64,
    parameter bit COMPRESSED = 1'b1,
    parameter int LIVE_LIMIT = 0,
    parameter int CNT_W      = 32,
    parameter bit ASSERT_EN  = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    rvfi_pc_order_check_if.slave rvfi,
    output logic                 err_pc,
    output logic                 err_order,
    output logic                 err_gap,
    output logic                 err_align,
    output logic                 err_live,
    output logic                 err_any,
    output logic [CNT_W-1:0]     ret_count
);
    localparam int CW = CNT_W + 1;

    typedef enum logic {
        NOBASE,
        TRACK
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]    shadow_pc_q;
    logic [ORDER_W-1:0] shadow_order_q;
    logic [XLEN-1:0]    ref_pc;
    logic [ORDER_W-1:0] ref_order;
    logic               have_ref;
    logic               any_valid;
    logic               pc_hit;
    logic               order_hit;
    logic               align_hit;
    logic               gap_hit;
    logic [CW-1:0]      pop;
    logic [CW-1:0]      sum;
    logic [CNT_W-1:0]   cnt_d;

    // Channels chain in index order: each valid one becomes the
    // reference for the next, seeded from the shadow registers.
    always_comb begin
        have_ref  = (state_q == TRACK);
        ref_pc    = shadow_pc_q;
        ref_order = shadow_order_q;
        any_valid = 1'b0;
        pc_hit    = 1'b0;
        order_hit = 1'b0;
        align_hit = 1'b0;
        gap_hit   = 1'b0;
        pop       = '0;
        for (int i = 0; i < NRET; i++) begin
            if (rvfi.rvfi_valid[i]) begin
                if (have_ref && !rvfi.rvfi_intr[i] &&
                    rvfi.rvfi_pc_rdata[i*XLEN +: XLEN] != ref_pc)
                    pc_hit = 1'b1;
                if (have_ref &&
                    rvfi.rvfi_order[i*ORDER_W +: ORDER_W] !=
                    ref_order + ORDER_W'(1))
                    order_hit = 1'b1;
                if (!rvfi.rvfi_trap[i] &&
                    (rvfi.rvfi_pc_wdata[i*XLEN] ||
                     (!COMPRESSED && rvfi.rvfi_pc_wdata[i*XLEN+1])))
                    align_hit = 1'b1;
                have_ref  = 1'b1;
                ref_pc    = rvfi.rvfi_pc_wdata[i*XLEN +: XLEN];
                ref_order = rvfi.rvfi_order[i*ORDER_W +: ORDER_W];
                any_valid = 1'b1;
                pop       = pop + CW'(1);
            end
        end
        for (int i = 1; i < NRET; i++) begin
            if (rvfi.rvfi_valid[i] && !rvfi.rvfi_valid[i-1])
                gap_hit = 1'b1;
        end
        state_d = any_valid ? TRACK : state_q;
        sum     = {1'b0, ret_count} + pop;
        cnt_d   = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= NOBASE;
            shadow_pc_q    <= '0;
            shadow_order_q <= '0;
            err_pc         <= 1'b0;
            err_order      <= 1'b0;
            err_gap        <= 1'b0;
            err_align      <= 1'b0;
            ret_count      <= '0;
        end else begin
            state_q        <= state_d;
            shadow_pc_q    <= ref_pc;
            shadow_order_q <= ref_order;
            err_pc         <= err_pc | pc_hit;
            err_order      <= err_order | order_hit;
            err_gap        <= err_gap | gap_hit;
            err_align      <= err_align | align_hit;
            ret_count      <= cnt_d;
        end
    end

    if (LIVE_LIMIT > 0) begin : g_live
        localparam int IW = $clog2(LIVE_LIMIT + 1);
        logic [IW-1:0] idle_q, idle_d;

        always_comb begin
            idle_d = idle_q;
            if (state_q != TRACK || any_valid)
                idle_d = '0;
            else if (idle_q < IW'(LIVE_LIMIT))
                idle_d = idle_q + IW'(1);
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                idle_q   <= '0;
                err_live <= 1'b0;
            end else begin
                idle_q   <= idle_d;
                err_live <= err_live | (idle_d == IW'(LIVE_LIMIT));
            end
        end

        if (ASSERT_EN) begin : g_live_assert
            always_ff @(posedge clk) begin
                if (resetn)
                    assert (idle_d != IW'(LIVE_LIMIT))
                    else $error("retirement stall limit reached");
            end
        end
    end else begin : g_no_live
        assign err_live = 1'b0;
    end

    if (ASSERT_EN) begin : g_assert
        always_ff @(posedge clk) begin
            if (resetn) begin
                assert (!pc_hit)
                else $error("pc_rdata off shadow pc");
                assert (!order_hit)
                else $error("order not shadow+1");
                assert (!gap_hit)
                else $error("valid channel above a hole");
                assert (!align_hit)
                else $error("misaligned pc_wdata");
            end
        end
    end

    assign err_any = err_pc | err_order | err_gap |
                     err_align | err_live;
endmodule

// File: tb/tb_rvfi_pc_order_check.sv
// Bench: two checkers on one RVFI bundle (strict/liveness and compressed),
// directed scenarios plus random retirement streams against a history model.
module tb_rvfi_pc_order_check;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rvfi_pc_order_check_if #(.NRET(2), .XLEN(32), .ORDER_W(8)) rvfi ();

    logic        a_pc, a_order, a_gap, a_align, a_live, a_any;
    logic [4:0]  a_cnt;
    logic        b_pc, b_order, b_gap, b_align, b_live, b_any;
    logic [31:0] b_cnt;

    rvfi_pc_order_check #(
        .NRET(2), .XLEN(32), .ORDER_W(8), .COMPRESSED(1'b0),
        .LIVE_LIMIT(4), .CNT_W(5), .ASSERT_EN(1'b0)
    ) dut_a (
        .clk(clk), .resetn(resetn), .rvfi(rvfi),
        .err_pc(a_pc), .err_order(a_order), .err_gap(a_gap),
        .err_align(a_align), .err_live(a_live), .err_any(a_any),
        .ret_count(a_cnt)
    );

    rvfi_pc_order_check #(
        .NRET(2), .XLEN(32), .ORDER_W(8), .COMPRESSED(1'b1),
        .LIVE_LIMIT(0), .CNT_W(32), .ASSERT_EN(1'b0)
    ) dut_b (
        .clk(clk), .resetn(resetn), .rvfi(rvfi),
        .err_pc(b_pc), .err_order(b_order), .err_gap(b_gap),
        .err_align(b_align), .err_live(b_live), .err_any(b_any),
        .ret_count(b_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  ord;
    } rec_t;

    rec_t hist[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_pc, m_order, m_gap, m_al_a, m_al_b, m_live;
    int   m_idle;
    longint m_cnt_a, m_cnt_b;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_err_pc", 64'(a_pc), 64'(m_pc));
        chk("a_err_order", 64'(a_order), 64'(m_order));
        chk("a_err_gap", 64'(a_gap), 64'(m_gap));
        chk("a_err_align", 64'(a_align), 64'(m_al_a));
        chk("a_err_live", 64'(a_live), 64'(m_live));
        chk("a_err_any", 64'(a_any),
            64'(m_pc | m_order | m_gap | m_al_a | m_live));
        chk("a_ret_count", 64'(a_cnt), 64'(m_cnt_a));
        chk("b_err_pc", 64'(b_pc), 64'(m_pc));
        chk("b_err_order", 64'(b_order), 64'(m_order));
        chk("b_err_gap", 64'(b_gap), 64'(m_gap));
        chk("b_err_align", 64'(b_align), 64'(m_al_b));
        chk("b_err_live", 64'(b_live), 64'd0);
        chk("b_err_any", 64'(b_any),
            64'(m_pc | m_order | m_gap | m_al_b));
        chk("b_ret_count", 64'(b_cnt), 64'(m_cnt_b));
    endtask

    // One clock: drive, update the model from the retirement rules,
    // then compare both checkers just after the edge.
    task automatic step(input logic rst_n, input logic [1:0] v,
                        input logic [15:0] o, input logic [63:0] r,
                        input logic [63:0] w, input logic [1:0] tr,
                        input logic [1:0] in);
        bit tracking;
        int pop;
        resetn             = rst_n;
        rvfi.rvfi_valid    = v;
        rvfi.rvfi_order    = o;
        rvfi.rvfi_pc_rdata = r;
        rvfi.rvfi_pc_wdata = w;
        rvfi.rvfi_trap     = tr;
        rvfi.rvfi_intr     = in;
        if (!rst_n) begin
            hist.delete();
            {m_pc, m_order, m_gap, m_al_a, m_al_b, m_live} = '0;
            m_idle  = 0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            tracking = hist.size() > 0;
            pop = 0;
            if (v == 2'b10) m_gap = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (v[i]) begin
                    rec_t rc;
                    logic [31:0] wi;
                    pop++;
                    rc.pc  = r[i*32 +: 32];
                    rc.ord = o[i*8 +: 8];
                    wi     = w[i*32 +: 32];
                    if (hist.size() > 0) begin
                        logic [7:0] nx;
                        nx = hist[$].ord + 8'd1;
                        if (!in[i] && rc.pc != hist[$].pc) m_pc = 1'b1;
                        if (rc.ord != nx) m_order = 1'b1;
                    end
                    if (!tr[i] && wi[1:0] != 2'b00) m_al_a = 1'b1;
                    if (!tr[i] && wi[0]) m_al_b = 1'b1;
                    rc.pc = wi;
                    hist.push_back(rc);
                    if (hist.size() > 8) void'(hist.pop_front());
                end
            end
            if (pop > 0) m_idle = 0;
            else if (tracking) begin
                m_idle++;
                if (m_idle >= 4) m_live = 1'b1;
            end
            m_cnt_a = m_cnt_a + pop;
            if (m_cnt_a > 31) m_cnt_a = 31;
            m_cnt_b = m_cnt_b + pop;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ret1(input logic [31:0] pc, input logic [7:0] od);
        step(1'b1, 2'b01, {8'h0, od}, {32'h0, pc},
             {32'h0, pc + 32'd4}, 2'b00, 2'b00);
    endtask

    task automatic idle();
        step(1'b1, 2'b00, 16'h0, 64'h0, 64'h0, 2'b00, 2'b00);
    endtask

    // Reset with live-looking retirements that must be ignored.
    task automatic rst();
        step(1'b0, 2'b11, 16'h0903, 64'h0000_0044_0000_0040,
             64'h0000_0049_0000_0044, 2'b00, 2'b00);
    endtask

    task automatic rand_step();
        logic [1:0]  v, tr, in;
        logic [15:0] o;
        logic [63:0] r, w;
        logic [31:0] pc, ri, wi;
        logic [7:0]  od, oi;
        int k;
        k = $urandom_range(0, 99);
        v = (k < 30) ? 2'b00 : (k < 65) ? 2'b01 :
            (k < 97) ? 2'b11 : 2'b10;
        pc = (hist.size() > 0) ? hist[$].pc :
             32'($urandom_range(0, 255)) << 2;
        od = (hist.size() > 0) ? hist[$].ord + 8'd1 :
             8'($urandom_range(0, 255));
        for (int i = 0; i < 2; i++) begin
            ri = ($urandom_range(0, 19) == 0) ? pc ^ 32'h10 : pc;
            oi = ($urandom_range(0, 19) == 0) ? od + 8'd2 : od;
            in[i] = ($urandom_range(0, 15) == 0);
            tr[i] = ($urandom_range(0, 15) == 0);
            wi = ri + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd4);
            if ($urandom_range(0, 29) == 0) wi = wi + 32'd1;
            r[i*32 +: 32] = ri;
            w[i*32 +: 32] = wi;
            o[i*8 +: 8]   = oi;
            if (v[i]) begin
                pc = wi;
                od = oi + 8'd1;
            end
        end
        step(1'b1, v, o, r, w, tr, in);
    endtask

    initial begin
        rvfi.rvfi_valid    = '0;
        rvfi.rvfi_order    = '0;
        rvfi.rvfi_pc_rdata = '0;
        rvfi.rvfi_pc_wdata = '0;
        rvfi.rvfi_trap     = '0;
        rvfi.rvfi_intr     = '0;

        rst();
        rst();
        chk("reset_any", 64'(a_any | b_any), 64'd0);
        chk("reset_cnt", 64'(a_cnt), 64'd0);

        // Clean single-channel stream.
        ret1(32'h0, 8'd0);
        ret1(32'h4, 8'd1);
        ret1(32'h8, 8'd2);
        chk("t1_cnt", 64'(a_cnt), 64'd3);
        chk("t1_any", 64'(a_any), 64'd0);

        // PC discontinuity, then the same jump tagged as interrupt.
        rst();
        ret1(32'h0, 8'd0);
        step(1'b1, 2'b01, 16'h0001, 64'h10, 64'h14, 2'b00, 2'b00);
        chk("t2_pc", 64'(a_pc), 64'd1);
        rst();
        ret1(32'h0, 8'd0);
        step(1'b1, 2'b01, 16'h0001, 64'h10, 64'h14, 2'b00, 2'b01);
        chk("t2_intr_pc", 64'(a_pc), 64'd0);

        // Two-channel chain then an order gap.
        rst();
        step(1'b1, 2'b11, 16'h0605, 64'h0000_0104_0000_0100,
             64'h0000_0108_0000_0104, 2'b00, 2'b00);
        chk("t3_order_early", 64'(a_order), 64'd0);
        step(1'b1, 2'b01, 16'h0008, 64'h108, 64'h10C, 2'b00, 2'b00);
        chk("t3_order", 64'(a_order), 64'd1);
        chk("t3_cnt", 64'(a_cnt), 64'd3);

        // Packing hole; alignment with and without trap.
        rst();
        step(1'b1, 2'b10, 16'h0000, 64'h0, 64'h4_0000_0000,
             2'b00, 2'b00);
        chk("t4_gap", 64'(a_gap), 64'd1);
        rst();
        step(1'b1, 2'b01, 16'h0, 64'h100, 64'h102, 2'b00, 2'b00);
        chk("t4_align", 64'(a_align), 64'd1);
        chk("t4_align_c", 64'(b_align), 64'd0);
        rst();
        step(1'b1, 2'b01, 16'h0, 64'h100, 64'h102, 2'b01, 2'b00);
        chk("t4_trap", 64'(a_any), 64'd0);

        // Liveness boundary at LIVE_LIMIT-1 and LIVE_LIMIT.
        rst();
        ret1(32'h0, 8'd0);
        repeat (3) idle();
        chk("t5_live3", 64'(a_live), 64'd0);
        rst();
        ret1(32'h0, 8'd0);
        repeat (4) idle();
        chk("t5_live4", 64'(a_live), 64'd1);
        rst();
        chk("t5_rst_any", 64'(a_any), 64'd0);
        chk("t5_rst_cnt", 64'(a_cnt), 64'd0);

        // Order wraps, reset held with valid, fresh baseline.
        ret1(32'h0, 8'd254);
        ret1(32'h4, 8'd255);
        ret1(32'h8, 8'd0);
        chk("t6_wrap", 64'(a_order), 64'd0);
        rst();
        rst();
        ret1(32'h80, 8'd77);
        chk("t6_base", 64'(a_any | b_any), 64'd0);

        // Counter saturation on the narrow checker.
        rst();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'b11,
                 {8'(2 * i + 1), 8'(2 * i)},
                 {32'(8 * i + 4), 32'(8 * i)},
                 {32'(8 * i + 8), 32'(8 * i + 4)},
                 2'b00, 2'b00);
        end
        chk("sat_a", 64'(a_cnt), 64'd31);
        chk("sat_b", 64'(b_cnt), 64'd40);

        // Random retirement streams.
        for (int blk = 0; blk < 40; blk++) begin
            rst();
            for (int s = 0; s < 30; s++) begin
                rand_step();
                if (s == 15) repeat ($urandom_range(0, 5)) idle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
